// File: rtl/hba_master_xfer_if.sv
// Signal bundle for one HBA bus master: local command/response handshake plus the
// arbiter and bus lines. The master modport is the engine's view; slave is the environment's.
interface hba_master_xfer_if #(
  parameter int DBUS_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rnw;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DBUS_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DBUS_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  hba_mrequest;
  logic                  hba_mgrant;
  logic                  hba_select;
  logic                  hba_rnw;
  logic [ADDR_WIDTH-1:0] hba_abus;
  logic [DBUS_WIDTH-1:0] hba_dbus;
  logic                  hba_xferack;
  logic [DBUS_WIDTH-1:0] hba_dbus_slave;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata,
    input  hba_mgrant, hba_xferack, hba_dbus_slave,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output hba_mrequest, hba_select, hba_rnw, hba_abus, hba_dbus
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata,
    output hba_mgrant, hba_xferack, hba_dbus_slave,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hba_mrequest, hba_select, hba_rnw, hba_abus, hba_dbus
  );
endinterface

// File: rtl/hba_master_xfer.sv
// HBA bus master transfer engine: one command at a time, arbitrate, drive the bus,
// wait for the ORed slave ack (or time out) and return a one-cycle response.
module hba_master_xfer #(
  parameter int DBUS_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input logic               hba_clk,
  input logic               hba_reset,
  hba_master_xfer_if.master bus
);

  localparam int                   CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic                  cmd_ready_reg, cmd_ready_next;
  logic                  mrequest_reg, mrequest_next;
  logic                  select_reg, select_next;
  logic                  rnw_reg, rnw_next;
  logic [ADDR_WIDTH-1:0] abus_reg, abus_next;
  logic [DBUS_WIDTH-1:0] dbus_reg, dbus_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DBUS_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  req_rnw_reg, req_rnw_next;
  logic [ADDR_WIDTH-1:0] req_addr_reg, req_addr_next;
  logic [DBUS_WIDTH-1:0] req_wdata_reg, req_wdata_next;
  logic [CNT_WIDTH-1:0]  tcnt_reg, tcnt_next;

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b1;
      mrequest_reg  <= 1'b0;
      select_reg    <= 1'b0;
      rnw_reg       <= 1'b0;
      abus_reg      <= '0;
      dbus_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      req_rnw_reg   <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      tcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= cmd_ready_next;
      mrequest_reg  <= mrequest_next;
      select_reg    <= select_next;
      rnw_reg       <= rnw_next;
      abus_reg      <= abus_next;
      dbus_reg      <= dbus_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      req_rnw_reg   <= req_rnw_next;
      req_addr_reg  <= req_addr_next;
      req_wdata_reg <= req_wdata_next;
      tcnt_reg      <= tcnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cmd_ready_next = cmd_ready_reg;
    mrequest_next  = mrequest_reg;
    select_next    = select_reg;
    rnw_next       = rnw_reg;
    abus_next      = abus_reg;
    dbus_next      = dbus_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    req_rnw_next   = req_rnw_reg;
    req_addr_next  = req_addr_reg;
    req_wdata_next = req_wdata_reg;
    tcnt_next      = tcnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_reg) begin
          req_rnw_next   = bus.cmd_rnw;
          req_addr_next  = bus.cmd_addr;
          req_wdata_next = bus.cmd_wdata;
          cmd_ready_next = 1'b0;
          mrequest_next  = 1'b1;
          state_next     = REQ;
        end
      end

      REQ: begin
        // Reads keep the write-data lines at zero so the bus stays clean.
        if (bus.hba_mgrant) begin
          select_next = 1'b1;
          abus_next   = req_addr_reg;
          rnw_next    = req_rnw_reg;
          dbus_next   = req_rnw_reg ? '0 : req_wdata_reg;
          tcnt_next   = '0;
          state_next  = XFER;
        end
      end

      XFER: begin
        // tcnt_reg holds the number of XFER cycles already completed; an ack on
        // the final cycle takes priority over the timeout.
        if (bus.hba_xferack || (tcnt_reg == CNT_LAST)) begin
          select_next    = 1'b0;
          rnw_next       = 1'b0;
          abus_next      = '0;
          dbus_next      = '0;
          mrequest_next  = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = !bus.hba_xferack;
          rsp_rdata_next = (bus.hba_xferack && req_rnw_reg) ? bus.hba_dbus_slave : '0;
          state_next     = DONE;
        end else if (tcnt_reg != CNT_MAX) begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end

      DONE: begin
        rsp_valid_next = 1'b0;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b0;
        cmd_ready_next = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready    = cmd_ready_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_rdata    = rsp_rdata_reg;
  assign bus.rsp_err      = rsp_err_reg;
  assign bus.hba_mrequest = mrequest_reg;
  assign bus.hba_select   = select_reg;
  assign bus.hba_rnw      = rnw_reg;
  assign bus.hba_abus     = abus_reg;
  assign bus.hba_dbus     = dbus_reg;

endmodule

// File: doc/hba_master_xfer.md
# hba_master_xfer

HBA bus master transfer engine: accepts one read or write command at a time from a local requester over a valid/ready handshake and arbitrates for the HBA bus. It then drives the address, control and write-data lines, waits for the ORed slave acknowledge and returns read data or a timeout error. It sits on the initiator side of the bus, opposite the slave peripherals whose `hba_xferack`/`hba_dbus_slave` outputs are ORed together.

## Interface
- `DBUS_WIDTH`, 8, data bus width.
- `ADDR_WIDTH`, 12, address width: upper 4 bits select the slave, lower bits select the register.
- `TIMEOUT`, 15, maximum cycles `hba_select` stays high awaiting ack; must be ≥1.

- `hba_clk`  in  1  single clock; all logic on rising edge.
- `hba_reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine idle, command accepted when `cmd_valid & cmd_ready`.
- `cmd_rnw`  in  1  1 = read, 0 = write.
- `cmd_addr`  in  ADDR_WIDTH  target address.
- `cmd_wdata`  in  DBUS_WIDTH  write data (ignored for reads).
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  DBUS_WIDTH  read data; 0 for writes or on error.
- `rsp_err`  out  1  transfer timed out; qualified by `rsp_valid`.
- `hba_mrequest`  out  1  bus request to arbiter.
- `hba_mgrant`  in  1  bus grant from arbiter.
- `hba_select`  out  1  transfer active.
- `hba_rnw`  out  1  direction of active transfer.
- `hba_abus`  out  ADDR_WIDTH  address of active transfer.
- `hba_dbus`  out  DBUS_WIDTH  master write data.
- `hba_xferack`  in  1  ORed slave acknowledge.
- `hba_dbus_slave`  in  DBUS_WIDTH  ORed slave read data.

## Operation
- All outputs registered. States: IDLE, REQ, XFER, DONE.
- IDLE: `cmd_ready`=1. On accept, latch rnw/addr/wdata, set `hba_mrequest`=1, go REQ.
- REQ: hold `hba_mrequest`. When `hba_mgrant` is sampled 1, drive `hba_select`=1, `hba_abus`=addr, `hba_rnw`=rnw and `hba_dbus`=wdata (0 for reads), clear the timeout counter, and go XFER. There is no grant timeout.
- XFER: bus lines held constant. Grant is not re-checked.
  - `hba_xferack` sampled 1: go DONE with `rsp_err`=0 and `rsp_rdata`=`hba_dbus_slave` (read) or 0 (write).
  - Else, if this is the TIMEOUT-th XFER cycle: go DONE with `rsp_err`=1 and `rsp_rdata`=0.
  - Ack on the timeout cycle wins; the response is not an error.
- On entry to DONE: `hba_select`, `hba_rnw`, `hba_abus`, `hba_dbus` and `hba_mrequest` go to 0, and `rsp_valid`=1 for exactly one cycle. The next state is IDLE. The DONE cycle provides bus turnaround.
- Idle bus convention: `hba_abus`, `hba_dbus` and `hba_rnw` are 0 whenever `hba_select`=0.
- `cmd_valid` outside IDLE is ignored; the command must be held until accepted.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates, with no wrap-around.
- `rsp_rdata`/`rsp_err` return to 0 the cycle after `rsp_valid`.

## Timing
- Reset: every output 0 except `cmd_ready`=1. State IDLE; any in-flight command is dropped and no response is issued. Reset asserted mid-XFER zeroes the bus lines at the next edge.
- Accept at edge E0 → `hba_mrequest`=1 after E0.
- Grant sampled at edge Eg (earliest E1) → `hba_select`=1 after Eg.
- Ack sampled at edge Ea → `hba_select`=0 and `rsp_valid`=1 after Ea → `cmd_ready`=1 after Ea+1.
- Minimum command-to-command spacing: 4 cycles, with grant already high and the slave acking in its first select cycle.
- Error case: `hba_select` high for exactly TIMEOUT cycles.

## Test plan
- Write, grant tied high: addr 0x123, wdata 0xA5, slave acks on 2nd select cycle → `hba_mrequest` at cycle 1, select/abus=0x123/rnw=0/dbus=0xA5 for 2 cycles, then `rsp_valid` for 1 cycle with err=0, rdata=0.
- Read: addr 0x2F0, slave returns 0x5A with ack on 1st select cycle → `hba_dbus`=0, `rsp_rdata`=0x5A, err=0, total 4 cycles to `cmd_ready`.
- Grant delayed 10 cycles → `hba_mrequest` high throughout, `hba_select` stays 0 until the cycle after grant is sampled.
- No ack, TIMEOUT=15 → `hba_select` high exactly 15 cycles, `rsp_err`=1, `rsp_rdata`=0. Ack on the 15th cycle instead → err=0.
- `cmd_valid` pulsed with a different command during XFER → ignored; bus lines unchanged; only the first response is issued.
- `hba_reset` for 1 cycle mid-XFER → all bus outputs 0 and `cmd_ready`=1 next cycle, no `rsp_valid`; a subsequent command completes normally.
